// File: rtl/free_list_if.sv
// Rename-stage free-list bus: retire/flush tag returns in, dispatch pops in,
// head-of-list peek and status out.
interface free_list_if #(
  parameter int N_WAY    = 2,
  parameter int N_ROB    = 8,
  parameter int CDB_BITS = 6
);
  logic [N_WAY*CDB_BITS-1:0] retire_told;
  logic [N_WAY-1:0]          retire_valid;
  logic                      branch_haz;
  logic [N_ROB*CDB_BITS-1:0] free_list_haz;
  logic [N_WAY-1:0]          dispatched;
  logic [N_WAY*CDB_BITS-1:0] free_tag;
  logic [N_WAY-1:0]          free_valid;
  logic [$clog2(N_WAY):0]    free_num;
  logic                      err;

  // Master is the rename/ROB side, slave is the free list itself.
  modport master (
    output retire_told, retire_valid, branch_haz, free_list_haz, dispatched,
    input  free_tag, free_valid, free_num, err
  );

  modport slave (
    input  retire_told, retire_valid, branch_haz, free_list_haz, dispatched,
    output free_tag, free_valid, free_num, err
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags for an R10K-style rename stage.
// Up to N_WAY pops per cycle; tags return from retirement and branch flush.
module free_list #(
  parameter int N_WAY      = 2,
  parameter int N_ROB      = 8,
  parameter int N_PHYS_REG = 64,
  parameter int CDB_BITS   = $clog2(N_PHYS_REG)
) (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave bus
);
  localparam int DEPTH = N_PHYS_REG - 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NUM_W = $clog2(N_WAY) + 1;
  localparam int N_SRC = N_WAY + N_ROB;

  typedef logic [CDB_BITS-1:0] tag_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  tag_t             list [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  logic [CNT_W-1:0] count;
  logic             err_q;

  function automatic ptr_t ptr_add(input ptr_t p, input int unsigned n);
    int unsigned s;
    s = (32'(p) + n) % DEPTH;
    return PTR_W'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Read path: zero-latency peek at the head of the list.
  // ---------------------------------------------------------------------------
  logic [N_WAY-1:0][CDB_BITS-1:0] peek;
  logic [N_WAY-1:0]               valid;
  logic [NUM_W-1:0]               num;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    peek  = '0;
    valid = '0;
    for (int k = 0; k < N_WAY; k++) begin
      peek[k]  = list[ptr_add(head, 32'(k))];
      valid[k] = 32'(count) > 32'(k);
    end
    num = (32'(count) > 32'(N_WAY)) ? NUM_W'(N_WAY) : NUM_W'(count);
  end

  assign bus.free_tag   = peek;
  assign bus.free_valid = valid;
  assign bus.free_num   = num;
  assign bus.err        = err_q;

  // ---------------------------------------------------------------------------
  // Pop / push bookkeeping.
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0] src_valid;
  tag_t             src_tag  [N_SRC];
  int unsigned      src_rank [N_SRC];
  int unsigned      pops;
  int unsigned      pushes;
  int unsigned      accepted;
  int unsigned      total;
  logic             pop_err;
  logic             over;

  always_comb begin
    pops    = 0;
    pop_err = 1'b0;
    // Flushed instructions never dispatch, so their pop requests are ignored.
    for (int k = 0; k < N_WAY; k++) begin
      if (bus.dispatched[k] && !bus.branch_haz) begin
        if (valid[k]) pops = pops + 1;
        else          pop_err = 1'b1;
      end
    end

    // Push sources in tail order: retire ways first, then flush slots.
    src_valid = '0;
    for (int k = 0; k < N_WAY; k++) begin
      src_tag[k]   = bus.retire_told[k*CDB_BITS +: CDB_BITS];
      src_valid[k] = bus.retire_valid[k] && (src_tag[k] != '0);
    end
    for (int i = 0; i < N_ROB; i++) begin
      src_tag[N_WAY+i]   = bus.free_list_haz[i*CDB_BITS +: CDB_BITS];
      src_valid[N_WAY+i] = bus.branch_haz && (src_tag[N_WAY+i] != '0);
    end

    pushes = 0;
    for (int j = 0; j < N_SRC; j++) begin
      src_rank[j] = pushes;
      if (src_valid[j]) pushes = pushes + 1;
    end

    total    = 32'(count) - pops + pushes;
    over     = total > 32'(DEPTH);
    accepted = over ? 32'(DEPTH) - (32'(count) - pops) : pushes;
  end

  // ---------------------------------------------------------------------------
  // State update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the array is reset on purpose: its initial contents are the free tags 32..N_PHYS_REG-1.
      for (int i = 0; i < DEPTH; i++) list[i] <= CDB_BITS'(32 + i);
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(DEPTH);
      err_q <= 1'b0;
    end else begin
      for (int j = 0; j < N_SRC; j++) begin
        if (src_valid[j] && (src_rank[j] < accepted))
          list[ptr_add(tail, src_rank[j])] <= src_tag[j];
      end
      head  <= ptr_add(head, pops);
      tail  <= ptr_add(tail, accepted);
      count <= over ? CNT_W'(DEPTH) : CNT_W'(total);
      err_q <= err_q | pop_err | over;
    end
  end
endmodule
